// File: rtl/colour_sequence_gen.sv
// Random one-hot colour sequence builder for the memory game.
// A 16-bit Galois LFSR (reseeded per game from an entropy word) fills a small
// buffer one entry per cycle; a registered read port serves the stored colours.
module colour_sequence_gen #(
  parameter int          MAX_LEN = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        append,
  input  logic [4:0]  length,
  input  logic [15:0] entropy,
  output logic        busy,
  output logic        done,
  output logic        full,
  output logic [4:0]  seqLength,
  input  logic [3:0]  rdIndex,
  output logic [3:0]  rdColour
);

  localparam logic [4:0] MAX_L = 5'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_GEN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr;
  logic [15:0] ent_q;
  logic [4:0]  target;
  logic [3:0]  slots [16];

  logic [15:0] stepped;
  logic [15:0] mixed;
  logic [4:0]  next_len;
  logic [4:0]  len_clamped;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] colour_of(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  assign stepped     = lfsr_step(lfsr);
  assign mixed       = lfsr ^ ent_q;
  assign next_len    = seqLength + 5'd1;
  assign len_clamped = (length == 5'd0) ? 5'd1 : ((length > MAX_L) ? MAX_L : length);

  assign busy = (state_q == S_SEED) || (state_q == S_GEN);
  assign done = (state_q == S_DONE);
  assign full = (seqLength == MAX_L);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a full append skips GEN and just acknowledges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start)       state_d = S_SEED;
        else if (append) state_d = full ? S_DONE : S_GEN;
      end
      S_SEED: state_d = S_GEN;
      S_GEN:  if (next_len == target) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: LFSR, length/target bookkeeping, buffer writes and the read port.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr      <= SEED;
      ent_q     <= '0;
      target    <= '0;
      seqLength <= '0;
      rdColour  <= '0;
      for (int i = 0; i < 16; i++) slots[i] <= '0;
    end else begin
      // Slots beyond the valid length read as blank so stale entries never leak.
      rdColour <= ({1'b0, rdIndex} < seqLength) ? slots[rdIndex] : 4'b0000;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            target    <= len_clamped;
            ent_q     <= entropy;
            seqLength <= '0;
          end else if (append && !full) begin
            target <= next_len;
          end
        end
        // An all-zero state would lock the LFSR, so fall back to the seed.
        S_SEED: lfsr <= (mixed == 16'h0000) ? SEED : mixed;
        S_GEN: begin
          lfsr                  <= stepped;
          slots[seqLength[3:0]] <= colour_of(stepped[1:0]);
          seqLength             <= next_len;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_colour_sequence_gen.sv
// Directed bench for colour_sequence_gen: table of start requests plus
// hand-written append, collision, and mid-build reset sequences.
module tb_colour_sequence_gen;

  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        append = 0;
  logic [4:0]  length = 0;
  logic [15:0] entropy = 0;
  logic        busy, done, full;
  logic [4:0]  seqLength;
  logic [3:0]  rdIndex = 0;
  logic [3:0]  rdColour;

  colour_sequence_gen dut (
    .clock(clock), .reset(reset), .start(start), .append(append),
    .length(length), .entropy(entropy), .busy(busy), .done(done),
    .full(full), .seqLength(seqLength), .rdIndex(rdIndex), .rdColour(rdColour)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model of the sequence contents.
  logic [15:0] mlfsr;
  logic [3:0]  mbuf [16];
  int          mlen;

  typedef struct {
    logic [4:0]  len;
    logic [15:0] ent;
    int          exp_len;
    logic        exp_full;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [15:0] m_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] m_colour(input logic [1:0] s);
    case (s)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mlfsr = 16'hACE1;
    mlen  = 0;
    for (int i = 0; i < 16; i++) mbuf[i] = 4'b0000;
  endtask

  task automatic model_gen();
    mlfsr = m_step(mlfsr);
    mbuf[mlen] = m_colour(mlfsr[1:0]);
    mlen++;
  endtask

  task automatic model_start(input int L, input logic [15:0] ent);
    mlfsr = mlfsr ^ ent;
    if (mlfsr == 16'h0000) mlfsr = 16'hACE1;
    mlen = 0;
    for (int i = 0; i < L; i++) model_gen();
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1; start = 0; append = 0;
    @(negedge clock);
    @(negedge clock); reset = 0;
    model_reset();
  endtask

  task automatic check_reads(input string name);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock); rdIndex = 4'(i);
      @(negedge clock);
      chk(name, {28'd0, rdColour}, {28'd0, (i < mlen) ? mbuf[i] : 4'b0000});
    end
  endtask

  // Start a build, then measure done latency and busy duration.
  task automatic do_start(input logic [4:0] len, input logic [15:0] ent, input int L,
                          input string name);
    int cyc, bc;
    bit got;
    @(negedge clock); start = 1; length = len; entropy = ent;
    @(negedge clock); start = 0; length = 5'h1F; entropy = 16'hFFFF;
    cyc = 1; bc = 0; got = 0;
    while (cyc <= 40) begin
      if (done) begin got = 1; break; end
      if (busy) bc++;
      @(negedge clock); cyc++;
    end
    model_start(L, ent);
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " done_cycle"}, 32'(cyc), 32'(L + 2));
    chk({name, " busy_cycles"}, 32'(bc), 32'(L + 1));
    chk({name, " seqLength"}, {27'd0, seqLength}, 32'(L));
  endtask

  task automatic do_append(input string name);
    int cyc, bc;
    bit got, was_full;
    was_full = (mlen == 16);
    @(negedge clock); append = 1;
    @(negedge clock); append = 0;
    cyc = 1; bc = 0; got = 0;
    while (cyc <= 20) begin
      if (done) begin got = 1; break; end
      if (busy) bc++;
      @(negedge clock); cyc++;
    end
    if (!was_full) model_gen();
    chk({name, " done_seen"}, 32'(got), 32'd1);
    if (was_full) begin
      chk({name, " done_by_2"}, 32'(cyc <= 2), 32'd1);
      chk({name, " busy_cycles"}, 32'(bc), 32'd0);
    end else begin
      chk({name, " done_cycle"}, 32'(cyc), 32'd2);
      chk({name, " busy_cycles"}, 32'(bc), 32'd1);
    end
    chk({name, " seqLength"}, {27'd0, seqLength}, 32'(mlen));
  endtask

  initial begin
    int cyc, dones;
    vecs[0] = '{5'd0,  16'h0001, 1,  1'b0};
    vecs[1] = '{5'd1,  16'h5A5A, 1,  1'b0};
    vecs[2] = '{5'd5,  16'h1234, 5,  1'b0};
    vecs[3] = '{5'd16, 16'hBEEF, 16, 1'b1};
    vecs[4] = '{5'd17, 16'h0F0F, 16, 1'b1};
    vecs[5] = '{5'd31, 16'h7777, 16, 1'b1};

    // Reset values.
    do_reset();
    @(negedge clock);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset full", 32'(full), 32'd0);
    chk("reset seqLength", {27'd0, seqLength}, 32'd0);
    chk("reset rdColour", {28'd0, rdColour}, 32'd0);

    // Length-5 build from seed ^ 1234, then three appends.
    do_start(5'd5, 16'h1234, 5, "t1");
    check_reads("t1 read");
    for (int k = 0; k < 3; k++) do_append("t3 append");
    chk("t3 len8", {27'd0, seqLength}, 32'd8);
    check_reads("t3 read");

    // Entropy equal to the seed mixes to zero; seed fallback stream is known.
    do_reset();
    do_start(5'd4, 16'hACE1, 4, "t2");
    check_reads("t2 read");
    @(negedge clock); rdIndex = 4'd0; @(negedge clock);
    chk("t2 entry0", {28'd0, rdColour}, 32'h1);
    @(negedge clock); rdIndex = 4'd3; @(negedge clock);
    chk("t2 entry3", {28'd0, rdColour}, 32'h4);

    // Clamping table.
    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].len, vecs[v].ent, vecs[v].exp_len, "tbl");
      chk("tbl full", 32'(full), 32'(vecs[v].exp_full));
      check_reads("tbl read");
    end

    // Append when full: acknowledged, no write.
    do_append("t4 full append");
    chk("t4 still full", 32'(full), 32'd1);
    check_reads("t4 read");

    // start + append together, then start again while busy.
    @(negedge clock); start = 1; append = 1; length = 5'd4; entropy = 16'h3C3C;
    @(negedge clock); start = 0; append = 0;
    dones = 0;
    if (done) dones++;
    @(negedge clock); start = 1; length = 5'd9; entropy = 16'h9999;
    if (done) dones++;
    @(negedge clock); start = 0;
    for (cyc = 3; cyc <= 20; cyc++) begin
      if (done) dones++;
      @(negedge clock);
    end
    model_start(4, 16'h3C3C);
    chk("t5 done_pulses", 32'(dones), 32'd1);
    chk("t5 seqLength", {27'd0, seqLength}, 32'd4);
    check_reads("t5 read");

    // Reset on the third GEN cycle of a length-10 build.
    @(negedge clock); start = 1; length = 5'd10; entropy = 16'h0042;
    @(negedge clock); start = 0;      // SEED
    @(negedge clock);                 // GEN 1
    @(negedge clock);                 // GEN 2
    @(negedge clock); reset = 1;      // GEN 3
    @(negedge clock);
    chk("t6 seqLength", {27'd0, seqLength}, 32'd0);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 done", 32'(done), 32'd0);
    reset = 0;
    model_reset();
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("t6 no_done", 32'(dones), 32'd0);
    check_reads("t6 read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
